// File: rtl/linear_fc_engine.sv
// Fully-connected layer engine: buffers one int8 feature vector, then streams OUT_DIM
// signed dot products against int8 weights read four-per-word from an external SRAM.
// Optional LINEAR_FC_RELU_EN clamps negative results to zero on the output.
module linear_fc_engine #(
  parameter int IN_DIM    = 40,
  parameter int OUT_DIM   = 40,
  parameter int ACC_W     = 24,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [9:0]       w_addr,
  input  logic [31:0]      w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [5:0]       out_idx,
  output logic             busy
);

  localparam int WPR = IN_DIM / 4;
  localparam int AW  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int KW  = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [1:0] {S_LOAD, S_FETCH, S_DRAIN, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic [5:0]               o_q, o_d;
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            kk_q, kk_d;
  logic                     rd_v_q, rd_v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [9:0]               addr_q, addr_d;
  logic                     act_we;
  logic [9:0]               fetch_addr;

  logic signed [7:0]        act_q [IN_DIM];
  logic [AW-1:0]            a_idx [4];
  logic signed [15:0]       prod  [4];
  logic signed [ACC_W-1:0]  mac_sum;

  always_ff @(posedge clk) begin
    if (act_we) act_q[cnt_q] <= in_data;
  end

  // Lane gi of the word holds the weight for feature 4*kk+gi (byte 0 = lowest feature).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign a_idx[gi] = AW'(4 * kk_q + gi);
    assign prod[gi]  = $signed(w_data[8*gi +: 8]) * act_q[a_idx[gi]];
  end

  assign mac_sum = ACC_W'(prod[0]) + ACC_W'(prod[1]) + ACC_W'(prod[2]) + ACC_W'(prod[3]);

  assign fetch_addr = 10'(BASE_ADDR) + 10'(o_q) * 10'(WPR) + 10'(k_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    k_d     = k_q;
    kk_d    = kk_q;
    rd_v_d  = 1'b0;
    acc_d   = acc_q;
    addr_d  = addr_q;
    act_we  = 1'b0;

    // First word of a row loads the accumulator, the rest accumulate.
    if (rd_v_q) acc_d = (kk_q == '0) ? mac_sum : acc_q + mac_sum;

    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          act_we = 1'b1;
          if (cnt_q == AW'(IN_DIM - 1)) begin
            cnt_d   = '0;
            o_d     = '0;
            k_d     = '0;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        addr_d = fetch_addr;
        rd_v_d = 1'b1;
        kk_d   = k_q;
        if (k_q == KW'(WPR - 1)) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (o_q == 6'(OUT_DIM - 1)) begin
            o_d     = '0;
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            o_d     = o_q + 1'b1;
            k_d     = '0;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      o_q     <= '0;
      k_q     <= '0;
      kk_q    <= '0;
      rd_v_q  <= 1'b0;
      acc_q   <= '0;
      addr_q  <= 10'(BASE_ADDR);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      k_q     <= k_d;
      kk_q    <= kk_d;
      rd_v_q  <= rd_v_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
    end
  end

  // Outside FETCH the address holds the last issued word, so stalls issue no new reads.
  assign w_addr    = (state_q == S_FETCH) ? fetch_addr : addr_q;
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign out_idx   = o_q;

`ifdef LINEAR_FC_RELU_EN
  assign out_data = acc_q[ACC_W-1] ? '0 : acc_q;
`else
  assign out_data = acc_q;
`endif

endmodule

// File: tb/tb_linear_fc_engine.sv
// Self-checking bench for linear_fc_engine: table-driven uniform vectors, byte-order/addressing,
// backpressure, mid-run reset and randomized vectors against a dot-product reference model.
module tb_linear_fc_engine;
  localparam int IN_DIM  = 40;
  localparam int OUT_DIM = 40;
  localparam int ACC_W   = 24;
  localparam int WPR     = IN_DIM / 4;
`ifdef LINEAR_FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic [9:0]       w_addr;
  logic [31:0]      w_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic [5:0]       out_idx;
  logic             busy;

  logic [31:0]      mem [1024];
  logic [7:0]       feat [IN_DIM];
  logic [ACC_W-1:0] exp_q [OUT_DIM];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]      wfill;
    logic [7:0]       ffill;
    logic [ACC_W-1:0] expv;
  } vec_t;
  vec_t tbl [4];

  linear_fc_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Weight SRAM with one cycle of read latency.
  always @(posedge clk) w_data <= mem[w_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain signed dot product of the stored features with row o, wrapped to ACC_W.
  function automatic logic [ACC_W-1:0] ref_row(input int o);
    int s = 0;
    logic [ACC_W-1:0] r;
    for (int i = 0; i < IN_DIM; i++) begin
      logic [31:0] w;
      logic [7:0]  wb;
      w  = mem[o * WPR + i / 4];
      wb = w[8 * (i % 4) +: 8];
      s += $signed(wb) * $signed(feat[i]);
    end
    r = s[ACC_W-1:0];
    if (RELU && r[ACC_W-1]) r = '0;
    return r;
  endfunction

  task automatic fill_uniform(input logic [31:0] w, input logic [7:0] f);
    foreach (mem[a]) mem[a] = w;
    foreach (feat[i]) feat[i] = f;
  endtask

  task automatic fill_random();
    foreach (mem[a]) mem[a] = $urandom;
    foreach (feat[i]) feat[i] = 8'($urandom);
    for (int o = 0; o < OUT_DIM; o++) exp_q[o] = ref_row(o);
  endtask

  task automatic send_vec(input bit bubbles);
    int i = 0;
    int guard = 0;
    while (i < IN_DIM && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = feat[i];
      end
      if (in_valid && in_ready) i++;
    end
    if (i < IN_DIM) check("load_timeout", i, IN_DIM);
  endtask

  // Drains results, checking each one plus address sequence, row latency and stall stability.
  task automatic collect(input bit rnd_ready, input bit garbage, input int stall_idx, input int stop_row);
    int n = 0, d = 0, guard = 0;
    int addr_bad = 0, lat_bad = 0, ir_bad = 0, stab_bad = 0;
    bit stalled = 1'b0, stopped = 1'b0;
    logic [9:0] base = 10'd0;
    logic [ACC_W-1:0] sd;
    logic [5:0] si;
    logic [9:0] sa;
    while (n < OUT_DIM && guard < 8000 && !stopped) begin
      @(negedge clk);
      guard++;
      d++;
      in_valid = garbage ? 1'($urandom) : 1'b0;
      in_data  = 8'($urandom);
      if (in_ready !== 1'b0 || busy !== 1'b1) ir_bad++;
      if (d <= WPR && w_addr !== base + 10'(d - 1)) addr_bad++;
      if (d == WPR + 1 && out_valid !== 1'b0) lat_bad++;
      if (d == WPR + 2 && out_valid !== 1'b1) lat_bad++;
      if (stop_row >= 0 && n == stop_row && d == 4) begin
        stopped = 1'b1;
      end else begin
        if (!stalled && out_valid && out_idx == 6'(stall_idx)) begin
          stalled   = 1'b1;
          out_ready = 1'b0;
          sd = out_data; si = out_idx; sa = w_addr;
          repeat (50) begin
            @(negedge clk);
            guard++;
            if (out_valid !== 1'b1 || out_data !== sd || out_idx !== si || w_addr !== sa) stab_bad++;
          end
          check("stall_stable", stab_bad, 0);
        end
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (out_valid && out_ready) begin
          check($sformatf("out_idx[%0d]", n), out_idx, n);
          check($sformatf("out_data[%0d]", n), out_data, exp_q[n]);
          n++;
          d = 0;
          base = 10'(n * WPR);
        end
      end
    end
    check("w_addr_seq", addr_bad, 0);
    check("row_latency", lat_bad, 0);
    check("in_ready_low", ir_bad, 0);
    if (stop_row < 0) check("result_count", n, OUT_DIM);
    else check("reached_stop_row", stopped, 1);
  endtask

  initial begin
    tbl[0] = '{32'h01010101, 8'h01, 24'd40};
    tbl[1] = '{32'h7F7F7F7F, 8'h80, RELU ? 24'h000000 : 24'hF61400};
    tbl[2] = '{32'hFFFFFFFF, 8'h01, RELU ? 24'h000000 : 24'hFFFFD8};
    tbl[3] = '{32'h80808080, 8'h80, 24'd655360};
    foreach (mem[a]) mem[a] = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      fill_uniform(tbl[t].wfill, tbl[t].ffill);
      foreach (exp_q[o]) exp_q[o] = tbl[t].expv;
      $display("table vector %0d weights=%h feature=%h", t, tbl[t].wfill, tbl[t].ffill);
      send_vec(1'b0);
      collect(1'b0, 1'b0, -1, -1);
    end

    // Byte order and row addressing: only word 0 of each row is non-zero.
    foreach (mem[a]) mem[a] = '0;
    for (int o = 0; o < OUT_DIM; o++) mem[o * WPR] = 32'h04030201;
    foreach (feat[i]) feat[i] = '0;
    for (int i = 0; i < 4; i++) feat[i] = 8'(i + 1);
    foreach (exp_q[o]) exp_q[o] = 24'd30;
    $display("byte order vector");
    send_vec(1'b0);
    collect(1'b0, 1'b0, -1, -1);

    // Random vector with a long stall at out_idx 5 and random backpressure.
    fill_random();
    $display("random vector with stall at idx 5");
    send_vec(1'b1);
    collect(1'b1, 1'b1, 5, -1);

    // Abort during FETCH of row 12, then run a fresh vector from scratch.
    fill_random();
    $display("random vector aborted at row 12");
    send_vec(1'b0);
    collect(1'b0, 1'b0, -1, 12);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_idx", out_idx, 0);
    check("midrst_w_addr", w_addr, 0);
    repeat (2) @(negedge clk);
    check("midrst_hold_in_ready", in_ready, 1);
    rst_n = 1'b1;
    fill_random();
    $display("random vector after reset with bubbles");
    send_vec(1'b1);
    collect(1'b1, 1'b1, -1, -1);

    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("final_in_ready", in_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/linear_fc_engine.md
Name: linear_fc_engine

Overview:
- Fully-connected layer datapath for the KWS classifier.
- Sits directly downstream of the weight SRAM wrapper: drives its 10-bit read address and consumes its 32-bit read data, four signed int8 weights per word.
- Buffers one int8 feature vector from the upstream feature stage, then computes OUT_DIM dot products.
- Streams signed accumulator results to the next stage over a valid/ready handshake.

Parameters:
- IN_DIM, 40, input features per vector; must be a multiple of 4.
- OUT_DIM, 40, output neurons.
- ACC_W, 24, signed accumulator and result width.
- WPR, IN_DIM/4 (10), weight words per output row; derived, not overridable.
- BASE_ADDR, 0, first weight word address in SRAM.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  feature byte valid.
- in_ready  output  1  engine accepts feature byte.
- in_data  input  8  signed int8 feature.
- w_addr  output  10  weight SRAM word address.
- w_data  input  32  weight SRAM read data; 1-cycle read latency.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  ACC_W  signed dot-product result.
- out_idx  output  6  output neuron index of out_data.
- busy  output  1  high in any state other than LOAD.

Behaviour:
- Reset: async assert on rst_n low.
  - State = LOAD; all counters 0; accumulator 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, w_addr=BASE_ADDR, busy=0.
- Clocking: single clock (clk); reset is asynchronous, active-low (rst_n).
- States: LOAD -> FETCH -> DRAIN -> OUT -> (FETCH | LOAD).
- LOAD:
  - in_ready=1. Each in_valid&in_ready cycle writes in_data to act[cnt] and increments cnt.
  - On acceptance of byte IN_DIM-1: in_ready drops next cycle, o=0, k=0, go to FETCH.
- FETCH:
  - Each cycle w_addr = BASE_ADDR + o*WPR + k; k increments.
  - A 1-deep valid pipe (rd_v) marks that w_data is valid next cycle.
  - After k=WPR-1 is issued, go to DRAIN.
- MAC: on every rd_v cycle with word index kk, acc += sum over b=0..3 of sext(w_data[8b+7:8b]) * act[4*kk+b].
  - Products are 16-bit signed; the sum is sign-extended to ACC_W.
  - Wrap-around on overflow; no saturation.
  - acc clears at the start of each row (first rd_v of the row loads instead of adds).
- DRAIN: one cycle absorbing the last read, then OUT.
- Latency: WPR+1 cycles from row start to out_valid.
- OUT:
  - out_valid=1, out_data=acc, out_idx=o, held stable until out_ready.
  - On out_valid&out_ready: if o==OUT_DIM-1, go to LOAD (cnt=0, in_ready=1 next cycle); else o++, k=0, FETCH.
- Backpressure: out_ready low holds OUT indefinitely. No SRAM reads are issued while stalled; w_addr holds its last value.
- Simultaneous events: in_valid is ignored outside LOAD (in_ready=0).
- Reset mid-operation: abort immediately, discard partial results, return to LOAD with the reset values above; the activation buffer contents are don't-care.
- Throughput: OUT_DIM*(WPR+2) cycles minimum per vector (480 at defaults), plus IN_DIM load cycles.

Optional Feature:
- Macro: LINEAR_FC_RELU_EN.
- Defined: out_data = (acc < 0) ? 0 : acc, i.e. ReLU fused on output.
- Undefined: out_data = raw signed acc.
- Timing and handshake are identical in both cases.

Test Plan:
- All weights 0x01010101, 40 features of 0x01 -> 40 results, each out_data=40, out_idx 0..39 in order.
- Weights 0x7F7F7F7F, features 0x80 (-128) -> each out_data = -650240 (0xF61400 at 24 bits). With LINEAR_FC_RELU_EN -> 0.
- Row o words = {0x04030201 at k=0, others 0}, features 1,2,3,4,0... -> out_data[o] = 1+4+9+16 = 30; checks byte order and row addressing. Check w_addr sequence o*10+0..9.
- out_ready held low 50 cycles at out_idx=5 -> out_valid/out_data/out_idx stable, w_addr frozen. Release -> out_idx 6 follows after WPR+1 cycles.
- rst_n pulsed low during FETCH of row 12 -> out_valid=0 and in_ready=1 within the reset. A fresh vector then yields a full 40 results starting at out_idx=0.
- in_valid toggling randomly during LOAD (bubbles) -> only handshaked bytes are stored; results match the reference model; in_ready=0 for the entire compute phase.
